// File: rtl/eth_rx_parser.sv
// rtl/eth_rx_parser.sv - Ethernet/IPv4/UDP receive parser with address filtering and FCS check

package eth_types_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ETH_HEADER,
        IP_HEADER,
        UDP_HEADER,
        PAYLOAD,
        FCS
    } eth_states;

    typedef struct packed {
        logic [47:0] dest_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
    } frame_header;

    // Only the IPv4 fields the parser filters on or reports are kept.
    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  header_len;
        logic [7:0]  protocol;
        logic [31:0] src_ip;
        logic [31:0] dest_ip;
    } ip_header;

    // The UDP checksum is never inspected, so it is not captured.
    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dest_port;
        logic [15:0] length;
    } udp_header;

    // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

endpackage

module eth_rx_parser
    import eth_types_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0164,
    parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_active,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        payload_valid,
    output logic [7:0]  payload_data,
    output logic        payload_last,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic [15:0] src_port,
    output logic [15:0] payload_len
);

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    eth_states   state, state_next;
    logic        armed, armed_next;
    logic [4:0]  cnt;
    logic [15:0] pay_cnt;
    logic [3:0]  fcs_cnt;
    logic [31:0] crc;
    frame_header eth_hdr;
    ip_header    ip_hdr;
    udp_header   udp_hdr;
    logic        byte_ok, filter_fail, header_end, latch_hdr, end_frame, pay_last_byte;

    assign byte_ok       = rx_active & rx_valid;
    assign pay_last_byte = (pay_cnt + 16'd1) == payload_len;

    // Filters look at captured fields once every byte of the field has been accepted.
    always_comb begin
        filter_fail = 1'b0;
        case (state)
            ETH_HEADER: filter_fail = (cnt >= 5'd6) && (eth_hdr.dest_mac != LOCAL_MAC) && (eth_hdr.dest_mac != '1);
            IP_HEADER:  filter_fail = (eth_hdr.ethertype != 16'h0800)
                                   || ((cnt >= 5'd1) && ((ip_hdr.version != 4'd4) || (ip_hdr.header_len != 4'd5)))
                                   || ((cnt >= 5'd10) && (ip_hdr.protocol != 8'd17));
            UDP_HEADER: filter_fail = (ip_hdr.dest_ip != LOCAL_IP)
                                   || ((cnt >= 5'd4) && (udp_hdr.dest_port != LOCAL_PORT))
                                   || ((cnt >= 5'd6) && (udp_hdr.length < 16'd8));
            default:    filter_fail = 1'b0;
        endcase
    end

    // Next-state logic: arming, header sequencing, filter aborts and frame end.
    always_comb begin
        state_next = state;
        armed_next = armed;
        header_end = 1'b0;
        latch_hdr  = 1'b0;
        end_frame  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_active) begin
                    armed_next = 1'b1;
                end else if (armed && rx_valid && (rx_data == 8'hD5)) begin
                    state_next = ETH_HEADER;
                    armed_next = 1'b0;
                end
            end
            ETH_HEADER, IP_HEADER, UDP_HEADER: begin
                if (!rx_active) begin
                    state_next = IDLE;
                    armed_next = 1'b1;
                end else if (filter_fail) begin
                    state_next = IDLE;
                    armed_next = 1'b0;
                end else if (rx_valid) begin
                    if (state == ETH_HEADER && cnt == 5'd13) begin
                        header_end = 1'b1;
                        state_next = IP_HEADER;
                    end else if (state == IP_HEADER && cnt == 5'd19) begin
                        header_end = 1'b1;
                        state_next = UDP_HEADER;
                    end else if (state == UDP_HEADER && cnt == 5'd7) begin
                        header_end = 1'b1;
                        latch_hdr  = 1'b1;
                        state_next = (udp_hdr.length == 16'd8) ? FCS : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (!rx_active) begin
                    state_next = IDLE;
                    armed_next = 1'b1;
                    end_frame  = 1'b1;
                end else if (rx_valid && pay_last_byte) begin
                    state_next = FCS;
                end
            end
            FCS: begin
                if (!rx_active) begin
                    state_next = IDLE;
                    armed_next = 1'b1;
                    end_frame  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                armed_next = 1'b0;
            end
        endcase
    end

    // State register and IDLE arm flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= armed_next;
        end
    end

    // Datapath: CRC, counters, header capture, payload forwarding and frame status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            pay_cnt       <= '0;
            fcs_cnt       <= '0;
            crc           <= 32'hFFFFFFFF;
            eth_hdr       <= '0;
            ip_hdr        <= '0;
            udp_hdr       <= '0;
            payload_valid <= 1'b0;
            payload_data  <= '0;
            payload_last  <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            src_mac       <= '0;
            src_ip        <= '0;
            src_port      <= '0;
            payload_len   <= '0;
        end else begin
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;

            if (state == IDLE) begin
                if (state_next == ETH_HEADER) begin
                    crc <= 32'hFFFFFFFF;
                    cnt <= '0;
                end
            end else if (byte_ok) begin
                crc <= crc32_byte(crc, rx_data);
            end

            if (byte_ok) begin
                case (state)
                    ETH_HEADER: begin
                        cnt <= header_end ? 5'd0 : cnt + 5'd1;
                        if (cnt < 5'd6)       eth_hdr.dest_mac  <= {eth_hdr.dest_mac[39:0], rx_data};
                        else if (cnt < 5'd12) eth_hdr.src_mac   <= {eth_hdr.src_mac[39:0], rx_data};
                        else                  eth_hdr.ethertype <= {eth_hdr.ethertype[7:0], rx_data};
                    end
                    IP_HEADER: begin
                        cnt <= header_end ? 5'd0 : cnt + 5'd1;
                        if (cnt == 5'd0)      {ip_hdr.version, ip_hdr.header_len} <= rx_data;
                        if (cnt == 5'd9)      ip_hdr.protocol <= rx_data;
                        if (cnt >= 5'd12 && cnt < 5'd16) ip_hdr.src_ip  <= {ip_hdr.src_ip[23:0], rx_data};
                        if (cnt >= 5'd16)     ip_hdr.dest_ip <= {ip_hdr.dest_ip[23:0], rx_data};
                    end
                    UDP_HEADER: begin
                        cnt <= header_end ? 5'd0 : cnt + 5'd1;
                        if (cnt < 5'd2)       udp_hdr.src_port  <= {udp_hdr.src_port[7:0], rx_data};
                        else if (cnt < 5'd4)  udp_hdr.dest_port <= {udp_hdr.dest_port[7:0], rx_data};
                        else if (cnt < 5'd6)  udp_hdr.length    <= {udp_hdr.length[7:0], rx_data};
                    end
                    PAYLOAD: begin
                        payload_valid <= 1'b1;
                        payload_data  <= rx_data;
                        payload_last  <= pay_last_byte;
                        pay_cnt       <= pay_cnt + 16'd1;
                    end
                    FCS: begin
                        if (fcs_cnt != 4'd15) fcs_cnt <= fcs_cnt + 4'd1;
                    end
                    default: ;
                endcase
            end

            if (latch_hdr) begin
                src_mac     <= eth_hdr.src_mac;
                src_ip      <= ip_hdr.src_ip;
                src_port    <= udp_hdr.src_port;
                payload_len <= udp_hdr.length - 16'd8;
                pay_cnt     <= '0;
                fcs_cnt     <= '0;
            end

            if (end_frame) begin
                frame_done <= 1'b1;
                frame_ok   <= (state == FCS) && (fcs_cnt >= 4'd4) && (crc == CRC_RESIDUE);
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_parser.sv
// tb/tb_eth_rx_parser.sv - scoreboard bench for eth_rx_parser with randomized frames

module tb_eth_rx_parser;

    localparam logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [31:0] LOCAL_IP   = 32'hC0A8_0164;
    localparam logic [15:0] LOCAL_PORT = 16'd5000;
    localparam logic [47:0] BCAST      = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_active = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        payload_valid, payload_last, frame_done, frame_ok;
    logic [7:0]  payload_data;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port, payload_len;

    eth_rx_parser #(
        .LOCAL_MAC (LOCAL_MAC),
        .LOCAL_IP  (LOCAL_IP),
        .LOCAL_PORT(LOCAL_PORT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_active    (rx_active),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .payload_valid(payload_valid),
        .payload_data (payload_data),
        .payload_last (payload_last),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .src_mac      (src_mac),
        .src_ip       (src_ip),
        .src_port     (src_port),
        .payload_len  (payload_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } pay_exp_t;

    typedef struct packed {
        logic        ok;
        logic [47:0] smac;
        logic [31:0] sip;
        logic [15:0] sport;
        logic [15:0] plen;
    } done_exp_t;

    pay_exp_t   pay_q[$];
    done_exp_t  done_q[$];
    logic [7:0] forced_pay[$];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every DUT output event is matched against the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (payload_valid) begin
                if (pay_q.size() == 0) begin
                    check("unexpected_payload_valid", 64'(payload_valid), 64'd0);
                end else begin
                    pay_exp_t p;
                    p = pay_q.pop_front();
                    check("payload_data", 64'(payload_data), 64'(p.data));
                    check("payload_last", 64'(payload_last), 64'(p.last));
                end
            end else if (payload_last) begin
                check("payload_last_without_valid", 64'(payload_last), 64'd0);
            end
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_frame_done", 64'(frame_done), 64'd0);
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    check("frame_ok", 64'(frame_ok), 64'(d.ok));
                    check("src_mac", 64'(src_mac), 64'(d.smac));
                    check("src_ip", 64'(src_ip), 64'(d.sip));
                    check("src_port", 64'(src_port), 64'(d.sport));
                    check("payload_len", 64'(payload_len), 64'(d.plen));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_payload_valid"}, 64'(payload_valid), 64'd0);
        check({tag, "_payload_data"}, 64'(payload_data), 64'd0);
        check({tag, "_payload_last"}, 64'(payload_last), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_frame_ok"}, 64'(frame_ok), 64'd0);
        check({tag, "_src_mac"}, 64'(src_mac), 64'd0);
        check({tag, "_src_ip"}, 64'(src_ip), 64'd0);
        check({tag, "_src_port"}, 64'(src_port), 64'd0);
        check({tag, "_payload_len"}, 64'(payload_len), 64'd0);
    endtask

    task automatic drive_byte(input logic [7:0] b);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
            rx_data  = 8'hD5;
        end
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Builds a frame from header field values, predicts the parser's response
    // from the acceptance rules, then drives it. cut >= 0 drops rx_active after
    // that many payload bytes; rst_at >= 0 pulses reset after that many frame bytes.
    task automatic send_frame(input logic [47:0] dmac, input logic [15:0] etype,
                              input logic [7:0] verihl, input logic [7:0] proto,
                              input logic [31:0] dip, input logic [15:0] dport,
                              input logic [15:0] ulen, input int npad, input bit bad_fcs,
                              input int cut, input bit noexp, input int rst_at);
        logic [7:0]  fr[$];
        logic [47:0] smac;
        logic [31:0] sip, c;
        logic [15:0] sport, total;
        int          plen, nsend;
        bit          accept;
        smac  = {16'($urandom), $urandom};
        sip   = $urandom;
        sport = 16'($urandom_range(1, 65535));
        plen  = (ulen >= 16'd8) ? int'(ulen) - 8 : 0;
        total = ulen + 16'd20;
        for (int i = 5; i >= 0; i--) fr.push_back(dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fr.push_back(smac[8*i +: 8]);
        fr.push_back(etype[15:8]); fr.push_back(etype[7:0]);
        fr.push_back(verihl); fr.push_back(8'h00);
        fr.push_back(total[15:8]); fr.push_back(total[7:0]);
        fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
        fr.push_back(8'h40); fr.push_back(8'h00); fr.push_back(8'd64); fr.push_back(proto);
        fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
        for (int i = 3; i >= 0; i--) fr.push_back(sip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) fr.push_back(dip[8*i +: 8]);
        fr.push_back(sport[15:8]); fr.push_back(sport[7:0]);
        fr.push_back(dport[15:8]); fr.push_back(dport[7:0]);
        fr.push_back(ulen[15:8]); fr.push_back(ulen[7:0]);
        fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
        for (int i = 0; i < plen; i++) fr.push_back((forced_pay.size() > 0) ? forced_pay.pop_front() : 8'($urandom));
        for (int i = 0; i < npad; i++) fr.push_back(8'($urandom));
        c = 32'hFFFFFFFF;
        foreach (fr[k]) begin
            for (int b = 0; b < 8; b++) c = (c[0] ^ fr[k][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        fr.push_back(c[7:0]); fr.push_back(c[15:8]); fr.push_back(c[23:16]);
        fr.push_back(c[31:24] ^ (bad_fcs ? 8'h01 : 8'h00));

        accept = ((dmac == LOCAL_MAC) || (dmac == BCAST)) && (etype == 16'h0800) && (verihl == 8'h45)
              && (proto == 8'd17) && (dip == LOCAL_IP) && (dport == LOCAL_PORT) && (ulen >= 16'd8);
        nsend = (cut >= 0) ? 42 + cut : fr.size();
        if (accept && !noexp && rst_at < 0) begin
            for (int i = 0; i < plen; i++) begin
                if (cut < 0 || i < cut) pay_q.push_back({fr[42+i], (i == plen - 1)});
            end
            done_q.push_back({(cut < 0) && !bad_fcs, smac, sip, sport, 16'(plen)});
        end

        @(posedge clk); #1;
        rx_active = 1'b1;
        for (int i = 0; i < 7; i++) drive_byte(8'h55);
        drive_byte(8'hD5);
        for (int k = 0; k < nsend; k++) begin
            if (k == rst_at) begin
                reset_pulse();
                return;
            end
            drive_byte(fr[k]);
        end
        @(posedge clk); #1;
        rx_valid  = 1'b0;
        rx_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = 8'hD5;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_good(input logic [15:0] ulen, input int npad);
        send_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'd17, LOCAL_IP, LOCAL_PORT, ulen, npad, 1'b0, -1, 1'b0, -1);
    endtask

    initial begin
        #2 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        forced_pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_good(16'd12, 14);
        forced_pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'd17, LOCAL_IP, LOCAL_PORT, 16'd12, 14, 1'b1, -1, 1'b0, -1);
        send_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'd17, LOCAL_IP, 16'd5001, 16'd12, 14, 1'b0, -1, 1'b0, -1);
        send_good(16'd10, 0);
        send_frame(BCAST, 16'h0800, 8'h45, 8'd17, LOCAL_IP, LOCAL_PORT, 16'd8, 18, 1'b0, -1, 1'b0, -1);
        forced_pay = '{8'h11, 8'hD5, 8'h22, 8'h33, 8'hD5, 8'h44};
        send_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'd17, LOCAL_IP, LOCAL_PORT, 16'd14, 0, 1'b0, 2, 1'b0, -1);
        forced_pay = '{8'hD5, 8'h55, 8'hD5};
        send_good(16'd11, 5);
        send_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'd17, LOCAL_IP, LOCAL_PORT, 16'd5, 10, 1'b0, -1, 1'b0, -1);

        send_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'd17, LOCAL_IP, LOCAL_PORT, 16'd12, 0, 1'b0, -1, 1'b0, 19);
        send_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'd17, LOCAL_IP, LOCAL_PORT, 16'd12, 0, 1'b0, -1, 1'b1, -1);
        send_good(16'd13, 3);

        for (int n = 0; n < 40; n++) begin
            logic [47:0] dmac;
            logic [15:0] etype, dport, ulen;
            logic [7:0]  verihl, proto;
            logic [31:0] dip;
            int          plen, npad, cut, kind;
            bit          bad;
            kind   = $urandom_range(0, 13);
            dmac   = ($urandom_range(0, 3) == 0) ? BCAST : LOCAL_MAC;
            etype  = 16'h0800;
            verihl = 8'h45;
            proto  = 8'd17;
            dip    = LOCAL_IP;
            dport  = LOCAL_PORT;
            plen   = $urandom_range(0, 24);
            ulen   = 16'(plen + 8);
            npad   = $urandom_range(0, 20);
            bad    = 1'b0;
            cut    = -1;
            case (kind)
                0: dmac   = LOCAL_MAC ^ {16'h0, $urandom | 32'h1};
                1: etype  = 16'h86DD;
                2: verihl = 8'h46;
                3: proto  = 8'd6;
                4: dip    = LOCAL_IP ^ 32'h1;
                5: dport  = LOCAL_PORT + 16'd1;
                6: ulen   = 16'($urandom_range(0, 7));
                7: bad    = 1'b1;
                8: cut    = $urandom_range(0, plen);
                default: ;
            endcase
            send_frame(dmac, etype, verihl, proto, dip, dport, ulen, npad, bad, cut, 1'b0, -1);
        end

        repeat (20) @(posedge clk);
        #1;
        check("payload_queue_drained", 64'(pay_q.size()), 64'd0);
        check("done_queue_drained", 64'(done_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
